// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// The fixed 34-cycle schedule runs IDLE -> RUN (32 iterations) -> FIN, with a Done pulse and RegFile write strobe.
module muldiv_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [2:0]            Funct3,
  input  logic [XLEN-1:0]       RD1,
  input  logic [XLEN-1:0]       RD2,
  input  logic [REG_ADDR_W-1:0] RdIn,
  output logic                  Busy,
  output logic                  Done,
  output logic [XLEN-1:0]       Result,
  output logic [REG_ADDR_W-1:0] RdOut,
  output logic                  RegWEn
);

  localparam int unsigned PW    = 2 * XLEN;
  localparam int unsigned CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [PW-1:0]         acc, acc_n;
  logic [XLEN-1:0]       op_a, op_a_n, op_b, op_b_n;
  logic [2:0]            funct, funct_n;
  logic                  neg_q, neg_q_n, neg_r, neg_r_n;
  logic [REG_ADDR_W-1:0] rd, rd_n;
  logic                  busy_n, done_n, regwen_n;
  logic [XLEN-1:0]       result_n;
  logic [REG_ADDR_W-1:0] rd_out_n;

  // Operand decode for a new request: signedness per op, magnitudes and result signs
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_signed = (Funct3 != 3'd3) && (Funct3 != 3'd5) && (Funct3 != 3'd7);
    b_signed = a_signed && (Funct3 != 3'd2);
    a_neg    = a_signed && RD1[XLEN-1];
    b_neg    = b_signed && RD2[XLEN-1];
    a_mag    = a_neg ? -RD1 : RD1;
    b_mag    = b_neg ? -RD2 : RD2;
  end

  // One iteration of each algorithm plus the sign-corrected final values
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_top;
  logic            div_ge;
  logic [XLEN-1:0] div_diff;
  logic [PW-1:0]   prod_s;
  logic [XLEN-1:0] quo_s, rem_s, fin_val;

  always_comb begin
    mul_sum  = {1'b0, acc[PW-1:XLEN]} + {1'b0, op_a};
    div_top  = acc[PW-1:XLEN-1];
    div_ge   = div_top >= {1'b0, op_b};
    div_diff = XLEN'(div_top - {1'b0, op_b});
    prod_s   = neg_q ? -acc : acc;
    quo_s    = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_s    = neg_r ? -acc[PW-1:XLEN] : acc[PW-1:XLEN];
    fin_val  = '0;
    if (!funct[2]) begin
      fin_val = (funct[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[PW-1:XLEN];
    end else if (op_b == '0) begin
      // Divide by zero: all-ones quotient, remainder is rs1 unchanged
      fin_val = funct[1] ? (neg_r ? -op_a : op_a) : {XLEN{1'b1}};
    end else begin
      fin_val = funct[1] ? rem_s : quo_s;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    acc_n    = acc;
    op_a_n   = op_a;
    op_b_n   = op_b;
    funct_n  = funct;
    neg_q_n  = neg_q;
    neg_r_n  = neg_r;
    rd_n     = rd;
    busy_n   = Busy;
    done_n   = 1'b0;
    regwen_n = 1'b0;
    result_n = Result;
    rd_out_n = RdOut;
    case (state)
      S_IDLE: begin
        if (Start) begin
          state_n = S_RUN;
          cnt_n   = '0;
          funct_n = Funct3;
          rd_n    = RdIn;
          op_a_n  = a_mag;
          op_b_n  = b_mag;
          neg_q_n = a_neg ^ b_neg;
          neg_r_n = a_neg;
          acc_n   = Funct3[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
          busy_n  = 1'b1;
        end
      end
      S_RUN: begin
        if (!funct[2]) begin
          acc_n = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[PW-1:1]};
        end else begin
          acc_n = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1} : {acc[PW-2:0], 1'b0};
        end
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_W'(XLEN - 1)) begin
          state_n = S_FIN;
          cnt_n   = '0;
        end
      end
      S_FIN: begin
        state_n  = S_IDLE;
        busy_n   = 1'b0;
        done_n   = 1'b1;
        result_n = fin_val;
        rd_out_n = rd;
        regwen_n = (rd != '0);
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      funct  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      rd     <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      RegWEn <= 1'b0;
      Result <= '0;
      RdOut  <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      acc    <= acc_n;
      op_a   <= op_a_n;
      op_b   <= op_b_n;
      funct  <= funct_n;
      neg_q  <= neg_q_n;
      neg_r  <= neg_r_n;
      rd     <= rd_n;
      Busy   <= busy_n;
      Done   <= done_n;
      RegWEn <= regwen_n;
      Result <= result_n;
      RdOut  <= rd_out_n;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: reset, multiply/divide results, divide corner cases,
// ignored Start while busy, x0 destination and back-to-back requests.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  Funct3 = '0;
  logic [31:0] RD1 = '0;
  logic [31:0] RD2 = '0;
  logic [4:0]  RdIn = '0;
  logic        Busy, Done, RegWEn;
  logic [31:0] Result;
  logic [4:0]  RdOut;

  int checks = 0;
  int failures = 0;

  muldiv_unit dut (
    .clock(clock), .Reset(Reset), .Start(Start), .Funct3(Funct3),
    .RD1(RD1), .RD2(RD2), .RdIn(RdIn),
    .Busy(Busy), .Done(Done), .Result(Result), .RdOut(RdOut), .RegWEn(RegWEn)
  );

  always #5 clock = ~clock;

  // Issue one request, return the number of edges after acceptance until Done (100 = timeout)
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat);
    @(negedge clock);
    Funct3 = f; RD1 = a; RD2 = b; RdIn = rd; Start = 1'b1;
    @(posedge clock); #1;
    Start = 1'b0;
    lat = 0;
    while (Done !== 1'b1 && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({Busy, Done, RegWEn, Result, RdOut} !== 40'd0) begin
      failures++; $display("FAIL reset_outputs got %h expected 0", {Busy, Done, RegWEn, Result, RdOut});
    end
    @(negedge clock); Reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (Busy !== 1'b0) begin
      failures++; $display("FAIL idle_after_release got Busy=%b expected 0", Busy);
    end
  endtask

  task automatic test_mul;
    int lat;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, lat);
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL mul_latency got %0d expected 33", lat); end
    checks++;
    if (Result !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_result got %h expected ffffffeb", Result); end
    checks++;
    if (RdOut !== 5'd5 || RegWEn !== 1'b1) begin
      failures++; $display("FAIL mul_writeback got rd=%0d wen=%b expected rd=5 wen=1", RdOut, RegWEn);
    end
    @(posedge clock); #1;
    checks++;
    if (Done !== 1'b0 || RegWEn !== 1'b0 || Result !== 32'hFFFF_FFEB) begin
      failures++; $display("FAIL done_pulse got done=%b wen=%b res=%h expected 0 0 ffffffeb", Done, RegWEn, Result);
    end
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, lat);
    checks++;
    if (lat !== 33 || Result !== 32'hFFFF_FFFE) begin
      failures++; $display("FAIL mulhu got lat=%0d res=%h expected 33 fffffffe", lat, Result);
    end
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, lat);
    checks++;
    if (lat !== 33 || Result !== 32'h0000_0000) begin
      failures++; $display("FAIL mulh got lat=%0d res=%h expected 33 00000000", lat, Result);
    end
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, lat);
    checks++;
    if (lat !== 33 || Result !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL mulhsu got lat=%0d res=%h expected 33 ffffffff", lat, Result);
    end
  endtask

  task automatic test_reset_abort;
    bit seen = 1'b0;
    @(negedge clock);
    Funct3 = 3'd4; RD1 = 32'hFFFF_FFEC; RD2 = 32'd3; RdIn = 5'd7; Start = 1'b1;
    @(posedge clock); #1;
    Start = 1'b0;
    checks++;
    if (Busy !== 1'b1) begin failures++; $display("FAIL busy_in_run got %b expected 1", Busy); end
    repeat (10) @(posedge clock);
    @(negedge clock); Reset = 1'b0;
    #1;
    checks++;
    if ({Busy, Done, Result, RdOut} !== 39'd0) begin
      failures++; $display("FAIL async_reset got %h expected 0", {Busy, Done, Result, RdOut});
    end
    @(negedge clock); Reset = 1'b1;
    repeat (50) begin
      @(posedge clock); #1;
      if (Done === 1'b1 || Busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL abandoned_op got activity=%b expected 0", seen); end
  endtask

  task automatic test_div_corners;
    int lat;
    run_op(3'd5, 32'd1984, 32'd0, 5'd3, lat);
    checks++;
    if (lat !== 33 || Result !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL divu_by_zero got lat=%0d res=%h expected 33 ffffffff", lat, Result);
    end
    run_op(3'd7, 32'd1984, 32'd0, 5'd3, lat);
    checks++;
    if (lat !== 33 || Result !== 32'd1984) begin
      failures++; $display("FAIL remu_by_zero got lat=%0d res=%h expected 33 000007c0", lat, Result);
    end
    run_op(3'd6, 32'hFFFF_FFEC, 32'd0, 5'd3, lat);
    checks++;
    if (lat !== 33 || Result !== 32'hFFFF_FFEC) begin
      failures++; $display("FAIL rem_by_zero got lat=%0d res=%h expected 33 ffffffec", lat, Result);
    end
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, lat);
    checks++;
    if (lat !== 33 || Result !== 32'h8000_0000) begin
      failures++; $display("FAIL div_overflow got lat=%0d res=%h expected 33 80000000", lat, Result);
    end
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, lat);
    checks++;
    if (lat !== 33 || Result !== 32'h0000_0000) begin
      failures++; $display("FAIL rem_overflow got lat=%0d res=%h expected 33 00000000", lat, Result);
    end
  endtask

  task automatic test_ignore_start;
    int  lat;
    bit  extra = 1'b0;
    @(negedge clock);
    Funct3 = 3'd4; RD1 = 32'd100; RD2 = 32'd7; RdIn = 5'd9; Start = 1'b1;
    @(posedge clock); #1;
    Start = 1'b0;
    lat = 0;
    while (Done !== 1'b1 && lat < 100) begin
      @(posedge clock); #1;
      lat++;
      if (lat == 10) begin Start = 1'b1; Funct3 = 3'd0; RD1 = 32'd1; RD2 = 32'd2; RdIn = 5'd12; end
      if (lat == 11) Start = 1'b0;
    end
    checks++;
    if (lat !== 33 || Result !== 32'd14 || RdOut !== 5'd9) begin
      failures++; $display("FAIL start_while_busy got lat=%0d res=%h rd=%0d expected 33 0000000e 9", lat, Result, RdOut);
    end
    repeat (40) begin
      @(posedge clock); #1;
      if (Done === 1'b1) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0) begin failures++; $display("FAIL queued_start got extra_done=%b expected 0", extra); end
    run_op(3'd0, 32'd2, 32'd3, 5'd0, lat);
    checks++;
    if (lat !== 33 || Done !== 1'b1 || RegWEn !== 1'b0 || Result !== 32'd6) begin
      failures++; $display("FAIL x0_dest got lat=%0d done=%b wen=%b res=%h expected 33 1 0 00000006", lat, Done, RegWEn, Result);
    end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2;
    run_op(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd1, lat1);
    checks++;
    if (lat1 !== 33 || Result !== 32'hFFFF_FFFA || RdOut !== 5'd1) begin
      failures++; $display("FAIL div_signed got lat=%0d res=%h rd=%0d expected 33 fffffffa 1", lat1, Result, RdOut);
    end
    run_op(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd2, lat2);
    checks++;
    if (lat2 !== 33 || Result !== 32'hFFFF_FFFE || RdOut !== 5'd2) begin
      failures++; $display("FAIL rem_back_to_back got lat=%0d res=%h rd=%0d expected 33 fffffffe 2", lat2, Result, RdOut);
    end
    run_op(3'd5, 32'd100, 32'd7, 5'd4, lat2);
    checks++;
    if (lat2 !== 33 || Result !== 32'd14) begin
      failures++; $display("FAIL divu got lat=%0d res=%h expected 33 0000000e", lat2, Result);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_reset_abort();
    test_div_corners();
    test_ignore_start();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
